seg7_scanner: RTL

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_bin2bcd.sv | 63 ++++++
 rtl/seg7_scanner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scanner.
//   state_t         FSM state encoding (IDLE / CONVERT / LOAD)
//   SEG_*           active-high segment patterns, bit0 = a ... bit6 = g
//   seg_decode()    BCD digit to active-high segment pattern
//   pow10()         10**n, used to size the overflow threshold
package seg7_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_LOAD    = 2'd2;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: sequential double-dabble binary-to-BCD converter.
//   clk_in, rst_in  clock, asynchronous active-high reset
//   start           pulse: capture bin and begin converting
//   bin             binary value, sampled when start is high
//   bcd             DIGITS packed BCD nibbles (nibble 0 = units); complete the cycle after done
//   done            high during the final shift cycle
// Takes exactly WIRES shift cycles. Digits beyond DIGITS are dropped; the caller flags overflow.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int unsigned WIRES  = 4,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [WIRES-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int unsigned CW = (WIRES > 1) ? $clog2(WIRES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIRES - 1);

  logic                active_q;
  logic [CW-1:0]       cnt_q;
  logic [WIRES-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] bcd_step;

  // Add-3 correction on every nibble, then shift in the next binary MSB.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_step = {adj[4*DIGITS-2:0], bin_q[WIRES-1]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bin_q    <= bin;
      bcd_q    <= '0;
    end else if (active_q) begin
      bcd_q <= bcd_step;
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

  assign done = active_q && (cnt_q == LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: converts a binary count to decimal and multiplexes it onto DIGITS
// 7-segment digits.
//   clk_in, rst_in  clock, asynchronous active-high reset
//   value_in        unsigned binary value to display
//   seg_out         segments a..g of the digit currently enabled (bit0 = a)
//   dp_out          decimal point, always inactive
//   an_out          one-hot digit enable, bit0 = least significant digit
//   busy_out        high while a conversion (CONVERT or LOAD) is in progress
// COMMON_ANODE=1 makes seg_out/dp_out/an_out active-low.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned WIRES        = 4,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_SCALE   = 16,
  parameter int unsigned COMMON_ANODE = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WIRES-1:0]  value_in,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [DIGITS-1:0] an_out,
  output logic              busy_out
);

  localparam int unsigned     IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic            INV    = (COMMON_ANODE != 0);
  localparam logic [6:0]      SEG_OFF = {7{INV}};
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{INV}};
  localparam longint unsigned LIMIT  = pow10(DIGITS);

  state_t               state_q, state_d;
  logic [WIRES-1:0]     value_q;
  logic                 valid_q;
  logic                 conv_start;
  logic                 conv_done;
  logic [4*DIGITS-1:0]  bcd;
  logic                 overflow;
  logic [6:0]           disp_q   [DIGITS];
  logic [6:0]           disp_new [DIGITS];
  logic [3:0]           nib;
  logic                 seen;
  logic [SCAN_SCALE-1:0] presc_q;
  logic [IDX_W-1:0]     idx_q;
  logic [6:0]           seg_q;
  logic [DIGITS-1:0]    an_q;

  seg7_bin2bcd #(
    .WIRES  (WIRES),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (conv_start),
    .bin    (value_in),
    .bcd    (bcd),
    .done   (conv_done)
  );

  // Conversion control
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!valid_q || (value_in != value_q)) begin
          conv_start = 1'b1;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: if (conv_done) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign overflow = (64'(value_q) >= LIMIT);

  // New display contents: dashes on overflow, otherwise numerals with leading zeros blanked.
  always_comb begin
    seen = 1'b0;
    nib  = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib  = bcd[4*i +: 4];
      seen = seen | (nib != 4'd0);
      if (overflow)             disp_new[i] = SEG_DASH;
      else if (seen || i == 0)  disp_new[i] = seg_decode(nib);
      else                      disp_new[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) disp_q[i] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      if (conv_start) value_q <= value_in;
      if (state_q == ST_LOAD) begin
        valid_q <= 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) disp_q[i] <= disp_new[i];
      end
    end
  end

  // Digit scan runs independently of the conversion FSM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_q + SCAN_SCALE'(1);
      if (&presc_q) begin
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      an_q  <= (DIGITS'(1) << idx_q) ^ AN_OFF;
      seg_q <= disp_q[idx_q] ^ SEG_OFF;
    end
  end

  assign seg_out  = seg_q;
  assign an_out   = an_q;
  assign dp_out   = INV;
  assign busy_out = (state_q != ST_IDLE);

endmodule
